// File: rtl/data_mem_responder.sv
// Data-memory responder: one valid/ready request at a time, WAIT_STATES idle cycles, one response beat.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lat_write;
  logic            lat_mis;
  logic [AW-1:0]   lat_idx;
  logic [63:0]     lat_wdata;

  logic [63:0]     mem [DEPTH_WORDS];

  logic            accept_c;
  logic            commit_c;
  logic            mem_we_c;
  logic            req_mis_c;
  logic            c_write;
  logic            c_mis;
  logic [AW-1:0]   c_idx;
  logic [63:0]     c_wdata;
  logic [63:0]     c_rdata;
  logic            unused_addr_c;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis_c = |req_addr[2:0];
`else
  assign req_mis_c = 1'b0;
`endif

  // Upper address bits wrap; byte offset only matters with alignment checking.
  assign unused_addr_c = ^{req_addr[63:AW+3], req_addr[2:0]};

  assign accept_c = req_valid && req_ready;

  // Commit operands: straight from the request when there are no wait states.
  always_comb begin
    c_write = lat_write;
    c_mis   = lat_mis;
    c_idx   = lat_idx;
    c_wdata = lat_wdata;
    if (state == S_IDLE) begin
      c_write = req_write;
      c_mis   = req_mis_c;
      c_idx   = req_addr[AW+2:3];
      c_wdata = req_wdata;
    end
  end

  always_comb begin
    commit_c = 1'b0;
    if (WAIT_STATES == 0) begin
      commit_c = accept_c;
    end else begin
      commit_c = (state == S_WAIT) && (cnt == '0);
    end
  end

  assign mem_we_c = commit_c && c_write && !c_mis && !reset;
  assign c_rdata  = (c_write || c_mis) ? 64'd0 : mem[c_idx];

  // Storage array is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      mem[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      lat_write  <= 1'b0;
      lat_mis    <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          resp_valid <= 1'b0;
          if (accept_c) begin
            lat_write <= req_write;
            lat_mis   <= req_mis_c;
            lat_idx   <= req_addr[AW+2:3];
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (commit_c) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= c_rdata;
              resp_err   <= c_mis;
            end else begin
              state <= S_WAIT;
              cnt   <= CW'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (commit_c) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= c_rdata;
            resp_err   <= c_mis;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
